// File: rtl/flow_speed_pkg.sv
// Shared types and helpers for the flow-speed measurement blocks.
package flow_speed_pkg;

  localparam int PKT_LEN_W = 16;

  typedef enum logic {
    PKT_IDLE = 1'b0,
    PKT_IN   = 1'b1
  } pkt_state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // A last beat always carries at least one byte, however large mty is.
  function automatic logic [31:0] beat_bytes(input logic last, input logic [31:0] mty,
                                             input int bytes);
    logic [31:0] b;
    b = 32'(bytes);
    if (!last) return b;
    if (mty >= b - 32'd1) return 32'd1;
    return b - mty;
  endfunction

endpackage

// File: rtl/axis_skid_buf.sv
// Two-entry skid buffer: 1-cycle latency, registered ready, full throughput.
module axis_skid_buf #(
  parameter int W = 73
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         in_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  input  logic         out_ready
);

  logic         main_vld, skid_vld, skid_nxt;
  logic [W-1:0] main_q, skid_q;
  logic         in_acc, main_free;

  assign in_acc    = in_valid & in_ready;
  assign main_free = !main_vld | out_ready;
  // Ready is only high while the skid slot is empty, so the skid never overflows.
  assign skid_nxt  = main_free ? 1'b0 : (skid_vld | in_acc);

  assign out_valid = main_vld;
  assign out_data  = main_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_vld <= 1'b0;
      skid_vld <= 1'b0;
      main_q   <= '0;
      skid_q   <= '0;
      in_ready <= 1'b0;
    end else begin
      if (main_free) begin
        if (skid_vld) begin
          main_q   <= skid_q;
          main_vld <= 1'b1;
        end else begin
          main_vld <= in_acc;
          if (in_acc) main_q <= in_data;
        end
      end else if (in_acc) begin
        skid_q <= in_data;
      end
      skid_vld <= skid_nxt;
      in_ready <= !skid_nxt;
    end
  end

endmodule

// File: rtl/axis_rate_meter.sv
// AXI-Stream pass-through that counts packets, bytes and runts per fixed window.
module axis_rate_meter
  import flow_speed_pkg::*;
#(
  parameter int DATA_W        = 64,
  parameter int MTY_W         = 8,
  parameter int CNT_W         = 32,
  parameter int WINDOW_CYCLES = 1000,
  parameter int MIN_PKT_BYTES = 64
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic              s_axis_tvalid,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic              s_axis_tlast,
  input  logic [MTY_W-1:0]  s_axis_tuser_mty,
  output logic              s_axis_tready,
  output logic              m_axis_tvalid,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tlast,
  output logic [MTY_W-1:0]  m_axis_tuser_mty,
  input  logic              m_axis_tready,
  output logic              stat_valid,
  output logic [CNT_W-1:0]  stat_pkts,
  output logic [CNT_W-1:0]  stat_bytes,
  output logic [CNT_W-1:0]  stat_runts,
  output logic              stat_ovf
);

  localparam int BYTES = DATA_W / 8;
  localparam int TMR_W = clog2(WINDOW_CYCLES);
  localparam int PW    = DATA_W + MTY_W + 1;
  localparam logic [PKT_LEN_W-1:0] MIN_LEN  = PKT_LEN_W'(MIN_PKT_BYTES);
  localparam logic [TMR_W-1:0]     TMR_LAST = TMR_W'(WINDOW_CYCLES - 1);

  logic [PW-1:0] out_payload;
  logic          accept;

  assign accept = s_axis_tvalid & s_axis_tready;

  axis_skid_buf #(.W(PW)) u_skid (
    .clk      (aclk),
    .rst      (areset),
    .in_valid (s_axis_tvalid),
    .in_data  ({s_axis_tlast, s_axis_tuser_mty, s_axis_tdata}),
    .in_ready (s_axis_tready),
    .out_valid(m_axis_tvalid),
    .out_data (out_payload),
    .out_ready(m_axis_tready)
  );

  assign {m_axis_tlast, m_axis_tuser_mty, m_axis_tdata} = out_payload;

  pkt_state_e           state_q, state_d;
  logic [PKT_LEN_W-1:0] pkt_len_q, len_base, len_total;
  logic [PKT_LEN_W:0]   len_sum;
  logic [31:0]          beat_b;
  logic                 eop, runt;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) state_q <= PKT_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (accept) state_d = s_axis_tlast ? PKT_IDLE : PKT_IN;
  end

  // In IDLE the incoming beat starts a new packet, so the running length is ignored.
  always_comb begin
    beat_b    = beat_bytes(s_axis_tlast, 32'(s_axis_tuser_mty), BYTES);
    len_base  = (state_q == PKT_IDLE) ? '0 : pkt_len_q;
    len_sum   = {1'b0, len_base} + (PKT_LEN_W+1)'(beat_b);
    len_total = len_sum[PKT_LEN_W] ? '1 : len_sum[PKT_LEN_W-1:0];
    eop       = accept & s_axis_tlast;
    runt      = eop & (len_total < MIN_LEN);
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset)      pkt_len_q <= '0;
    else if (accept) pkt_len_q <= s_axis_tlast ? '0 : len_total;
  end

  // Top bit of the result flags that the add saturated.
  function automatic logic [CNT_W:0] sat_inc(input logic [CNT_W-1:0] acc,
                                             input logic [CNT_W-1:0] inc);
    logic [CNT_W:0] s;
    s = {1'b0, acc} + {1'b0, inc};
    return s[CNT_W] ? {1'b1, {CNT_W{1'b1}}} : s;
  endfunction

  logic [TMR_W-1:0] timer_q;
  logic [CNT_W-1:0] acc_pkts, acc_bytes, acc_runts;
  logic             acc_ovf, ovf_n, tc;
  logic [CNT_W:0]   pkts_n, bytes_n, runts_n;

  assign tc      = (timer_q == TMR_LAST);
  assign pkts_n  = sat_inc(acc_pkts, CNT_W'(eop));
  assign bytes_n = sat_inc(acc_bytes, accept ? CNT_W'(beat_b) : '0);
  assign runts_n = sat_inc(acc_runts, CNT_W'(runt));
  assign ovf_n   = acc_ovf | pkts_n[CNT_W] | bytes_n[CNT_W] | runts_n[CNT_W];

  // Terminal-count accepts fold into the closing window's snapshot.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      timer_q    <= '0;
      acc_pkts   <= '0;
      acc_bytes  <= '0;
      acc_runts  <= '0;
      acc_ovf    <= 1'b0;
      stat_valid <= 1'b0;
      stat_pkts  <= '0;
      stat_bytes <= '0;
      stat_runts <= '0;
      stat_ovf   <= 1'b0;
    end else begin
      stat_valid <= tc;
      if (tc) begin
        timer_q    <= '0;
        acc_pkts   <= '0;
        acc_bytes  <= '0;
        acc_runts  <= '0;
        acc_ovf    <= 1'b0;
        stat_pkts  <= pkts_n[CNT_W-1:0];
        stat_bytes <= bytes_n[CNT_W-1:0];
        stat_runts <= runts_n[CNT_W-1:0];
        stat_ovf   <= ovf_n;
      end else begin
        timer_q    <= timer_q + TMR_W'(1);
        acc_pkts   <= pkts_n[CNT_W-1:0];
        acc_bytes  <= bytes_n[CNT_W-1:0];
        acc_runts  <= runts_n[CNT_W-1:0];
        acc_ovf    <= ovf_n;
      end
    end
  end

endmodule

// File: tb/tb_axis_rate_meter.sv
// Bench for axis_rate_meter: directed + random traffic against a per-window scoreboard.
module tb_axis_rate_meter;

  localparam int DATA_W = 64;
  localparam int MTY_W  = 8;
  localparam int CNT_W  = 32;
  localparam int WIN    = 100;
  localparam int MINB   = 64;
  localparam int BYTES  = DATA_W / 8;
  localparam int NWIN   = 256;

  typedef logic [DATA_W+MTY_W:0] beat_t;

  logic              aclk = 1'b0;
  logic              areset = 1'b1;
  logic              s_axis_tvalid, s_axis_tlast, s_axis_tready;
  logic [DATA_W-1:0] s_axis_tdata;
  logic [MTY_W-1:0]  s_axis_tuser_mty;
  logic              m_axis_tvalid, m_axis_tlast, m_axis_tready;
  logic [DATA_W-1:0] m_axis_tdata;
  logic [MTY_W-1:0]  m_axis_tuser_mty;
  logic              stat_valid, stat_ovf;
  logic [CNT_W-1:0]  stat_pkts, stat_bytes, stat_runts;

  always #5 aclk = ~aclk;

  axis_rate_meter #(
    .DATA_W(DATA_W), .MTY_W(MTY_W), .CNT_W(CNT_W),
    .WINDOW_CYCLES(WIN), .MIN_PKT_BYTES(MINB)
  ) dut (
    .aclk(aclk), .areset(areset),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tdata(s_axis_tdata),
    .s_axis_tlast(s_axis_tlast), .s_axis_tuser_mty(s_axis_tuser_mty),
    .s_axis_tready(s_axis_tready),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tdata(m_axis_tdata),
    .m_axis_tlast(m_axis_tlast), .m_axis_tuser_mty(m_axis_tuser_mty),
    .m_axis_tready(m_axis_tready),
    .stat_valid(stat_valid), .stat_pkts(stat_pkts), .stat_bytes(stat_bytes),
    .stat_runts(stat_runts), .stat_ovf(stat_ovf)
  );

  int tests = 0;
  int fails = 0;
  int timeouts = 0;
  logic chk_to = 1'b0;
  logic to_done = 1'b0;
  logic rnd_done = 1'b0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: accepted-but-not-forwarded beats, and per-window totals from the byte rules.
  beat_t  exp_q[$];
  int     edges;
  logic   started;
  longint cur_len;
  longint w_pkts[NWIN], w_bytes[NWIN], w_runts[NWIN];
  logic   stall_prev;
  beat_t  hold_prev;
  longint last_p, last_b, last_r;

  // Inputs change only at posedge+1, so a handshake seen here happens at the next edge.
  always @(negedge aclk) begin
    if (areset) begin
      check("reset_path", {s_axis_tready, m_axis_tvalid, m_axis_tlast, m_axis_tuser_mty, m_axis_tdata}, '0);
      check("reset_stat", {stat_valid, stat_ovf, stat_pkts, stat_bytes, stat_runts}, '0);
      exp_q.delete();
      edges = 0; started = 1'b0; cur_len = 0; stall_prev = 1'b0;
      last_p = 0; last_b = 0; last_r = 0;
      for (int i = 0; i < NWIN; i++) begin w_pkts[i] = 0; w_bytes[i] = 0; w_runts[i] = 0; end
    end else begin
      if (started) edges++;
      started = 1'b1;
      check("s_tready", s_axis_tready, (edges > 0 && exp_q.size() < 2));
      check("m_tvalid", m_axis_tvalid, exp_q.size() > 0);
      if (stall_prev)
        check("hold_stable", {m_axis_tvalid, m_axis_tlast, m_axis_tuser_mty, m_axis_tdata}, {1'b1, hold_prev});
      if (m_axis_tvalid && exp_q.size() > 0)
        check("out_beat", {m_axis_tlast, m_axis_tuser_mty, m_axis_tdata}, exp_q[0]);
      check("stat_valid", stat_valid, (edges > 0 && edges % WIN == 0));
      if (stat_valid) begin
        int w;
        w = edges / WIN - 1;
        if (w >= 0 && w < NWIN) begin
          check("stat_pkts", stat_pkts, w_pkts[w]);
          check("stat_bytes", stat_bytes, w_bytes[w]);
          check("stat_runts", stat_runts, w_runts[w]);
          check("stat_ovf", stat_ovf, 1'b0);
          last_p = w_pkts[w]; last_b = w_bytes[w]; last_r = w_runts[w];
        end
      end else begin
        check("stat_hold", {stat_pkts, stat_bytes, stat_runts}, {CNT_W'(last_p), CNT_W'(last_b), CNT_W'(last_r)});
      end
      stall_prev = m_axis_tvalid && !m_axis_tready;
      hold_prev  = {m_axis_tlast, m_axis_tuser_mty, m_axis_tdata};
      if (m_axis_tvalid && m_axis_tready && exp_q.size() > 0) void'(exp_q.pop_front());
      if (s_axis_tvalid && s_axis_tready) begin
        int w;
        longint bb;
        w  = edges / WIN;
        bb = !s_axis_tlast ? BYTES
           : (s_axis_tuser_mty >= BYTES - 1) ? 1 : BYTES - s_axis_tuser_mty;
        exp_q.push_back({s_axis_tlast, s_axis_tuser_mty, s_axis_tdata});
        cur_len += bb;
        if (w < NWIN) begin
          w_bytes[w] += bb;
          if (s_axis_tlast) begin
            w_pkts[w]++;
            if (cur_len < MINB) w_runts[w]++;
          end
        end
        if (s_axis_tlast) cur_len = 0;
      end
      if (chk_to && !to_done) begin
        check("send_timeouts", timeouts, 0);
        to_done = 1'b1;
      end
    end
  end

  task automatic cyc();
    @(posedge aclk);
    #1;
  endtask

  task automatic send_beat(input logic [DATA_W-1:0] d, input logic l, input logic [MTY_W-1:0] mty);
    int n;
    n = 0;
    s_axis_tvalid = 1'b1; s_axis_tdata = d; s_axis_tlast = l; s_axis_tuser_mty = mty;
    while (!s_axis_tready && n < 1000) begin cyc(); n++; end
    if (n >= 1000) timeouts++;
    cyc();
    s_axis_tvalid = 1'b0;
  endtask

  task automatic send_pkt(input int nbeats, input logic [MTY_W-1:0] last_mty, input int gap_max);
    for (int i = 0; i < nbeats; i++) begin
      logic last;
      last = (i == nbeats - 1);
      send_beat({$urandom, $urandom}, last, last ? last_mty : MTY_W'($urandom));
      repeat ($urandom_range(0, gap_max)) cyc();
    end
  endtask

  // Next edge has 1-based index with (index-1) % WIN == p, i.e. timer value p.
  task automatic wait_win_pos(input int p);
    int n;
    n = 0;
    while ((edges + 1) % WIN != p && n < 300) begin cyc(); n++; end
    if (n >= 300) timeouts++;
  endtask

  initial begin
    s_axis_tvalid = 1'b0; s_axis_tdata = '0; s_axis_tlast = 1'b0; s_axis_tuser_mty = '0;
    m_axis_tready = 1'b1;
    repeat (4) cyc();
    areset = 1'b0;
    repeat (3) cyc();

    // 13 beats, mty=1 on last: 103 bytes
    wait_win_pos(0);
    send_pkt(13, 8'd1, 0);

    // same packet with a 9-cycle downstream stall
    wait_win_pos(0);
    fork
      send_pkt(13, 8'd1, 0);
      begin repeat (4) cyc(); m_axis_tready = 1'b0; repeat (9) cyc(); m_axis_tready = 1'b1; end
    join

    // 37-byte runt then a 64-byte packet in one window
    wait_win_pos(0);
    send_pkt(5, 8'd3, 0);
    send_pkt(8, 8'd0, 0);

    // mty clamping on last beats; mty ignored on non-last
    wait_win_pos(0);
    send_pkt(1, 8'd8, 1);
    send_pkt(1, 8'd255, 1);
    send_beat({$urandom, $urandom}, 1'b0, 8'd5);
    send_beat({$urandom, $urandom}, 1'b1, 8'd0);

    // accept on the terminal-count cycle, then an idle window
    wait_win_pos(WIN - 1);
    send_beat({$urandom, $urandom}, 1'b1, 8'd0);
    repeat (210) cyc();

    // reset mid-packet with the skid buffer full
    m_axis_tready = 1'b0;
    send_beat({$urandom, $urandom}, 1'b0, 8'd0);
    send_beat({$urandom, $urandom}, 1'b0, 8'd0);
    #2 areset = 1'b1;
    repeat (3) cyc();
    areset = 1'b0;
    m_axis_tready = 1'b1;
    send_pkt(3, 8'd0, 0);
    repeat (250) cyc();

    // random packets against random backpressure
    fork
      begin
        for (int k = 0; k < 30; k++) send_pkt($urandom_range(1, 12), MTY_W'($urandom), 3);
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin cyc(); m_axis_tready = ($urandom % 4) != 0; end
      end
    join
    m_axis_tready = 1'b1;
    repeat (250) cyc();

    chk_to = 1'b1;
    repeat (3) cyc();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
